key_scheduler: RTL
==================

# key_scheduler

Round-robin scheduler that shares a single command consumer among several debounced buttons. Each button path is a `KeyFilter` instance that produces at most one single-cycle pulse per press. This block sits between those filters and the control FSM. It latches each press as a pending request, grants one request per cycle in round-robin order, and queues the granted key indices in a small FIFO. The consumer drains the FIFO with a valid/ready handshake.

## Interface
- NKEYS, 4: number of filtered key inputs, 2..8.
- DEPTH, 4: FIFO entries, power of two, 2..16.
- IDW, $clog2(NKEYS): key-index width.
- CW, $clog2(DEPTH)+1: FIFO occupancy width.

- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- KEY_PULSE  input  NKEYS  one-cycle press pulses from the filters; any combination may be high in one cycle.
- CMD_READY  input  1  consumer accepts the head entry this cycle.
- CMD_VALID  output  1  FIFO not empty.
- CMD_ID  output  IDW  key index at the FIFO head; 0 when CMD_VALID=0.
- PENDING  output  NKEYS  latched, not-yet-queued requests.
- FIFO_COUNT  output  CW  entries held, 0..DEPTH.
- DROP_CNT  output  8  coalesced presses, saturating at 255.

## Operation
- Reset: PENDING=0, FIFO empty (CMD_VALID=0, CMD_ID=0, FIFO_COUNT=0), DROP_CNT=0. Round-robin pointer LAST=NKEYS-1, so key 0 has first priority.
- Request latch, per key k:
  - PENDING[k] sets on KEY_PULSE[k].
  - PENDING[k] clears when key k is granted.
  - If key k is granted and KEY_PULSE[k] is high in the same cycle, PENDING[k] stays 1; the new press is not lost.
  - If KEY_PULSE[k]=1, PENDING[k] is already 1 and key k is not granted that cycle, the press is coalesced and DROP_CNT increments by 1, saturating at 255.
  - Several keys may coalesce in one cycle; DROP_CNT adds the number of coalesced keys that cycle, saturating.
- Arbiter:
  - Combinational search of PENDING, starting at (LAST+1) mod NKEYS and wrapping.
  - The first set bit is the grant, provided the FIFO can accept.
  - On a grant, LAST takes the granted index.
  - No grant means LAST holds.
  - At most one grant per cycle.
- FIFO accept rule: push allowed when FIFO_COUNT<DEPTH, or when FIFO_COUNT==DEPTH and a pop occurs in the same cycle.
- FIFO:
  - Circular buffer with read and write pointers modulo DEPTH.
  - Pop when CMD_VALID && CMD_READY.
  - Push and pop in the same cycle leaves FIFO_COUNT unchanged.
  - CMD_READY while empty has no effect.
- Arithmetic: FIFO_COUNT never exceeds DEPTH or drops below 0. Pointers wrap from DEPTH-1 to 0.

## Timing
- Idle to command latency:
  - KEY_PULSE[k] high at edge t means PENDING[k]=1 after edge t.
  - The grant is taken at edge t+1, so CMD_VALID=1 with CMD_ID=k after edge t+1.
  - Total: 2 cycles.
- Sustained throughput: one grant per cycle and one pop per cycle.
- CMD_VALID and CMD_ID are driven from registered FIFO state only. They never depend combinationally on KEY_PULSE or CMD_READY.
- Handshake: once CMD_VALID=1, CMD_ID is stable until the pop. The consumer may hold CMD_READY high permanently.
- FIFO full and no pop: PENDING bits hold, no grant is made, LAST does not advance, and no request is lost beyond coalescing.
- RST asserted mid-operation: all state returns to reset values immediately (asynchronously). In-flight pending requests and queued entries are discarded.

## Test plan
- Reset mid-stream: fill the FIFO with 3 entries and set PENDING=4'b0101, then pulse RST between clock edges. Required: all outputs read 0 before the next edge; a following KEY_PULSE=4'b0001 yields CMD_ID=0 two cycles later.
- Single press: with the bench idle, CMD_READY=1 and KEY_PULSE=4'b0100 for one cycle. Required: CMD_VALID=1 with CMD_ID=2 exactly 2 cycles later; CMD_VALID=0 on the next cycle; DROP_CNT=0.
- Simultaneous presses: after reset, KEY_PULSE=4'b1111 for one cycle with CMD_READY=0. Required:
  - FIFO holds 0,1,2,3 in that order and FIFO_COUNT=4 after 5 cycles.
  - PENDING=0.
  - Raising CMD_READY then drains IDs 0,1,2,3 on consecutive cycles.
- Round-robin fairness: after key 1 is granted, set PENDING to 4'b0011 and 4'b1000 at the same time. Required grant order: 3, 0, 1.
- Full and coalesce: with CMD_READY=0, push 4 entries, then pulse key 2 on three separate cycles. Required:
  - FIFO_COUNT=4 and PENDING[2]=1.
  - DROP_CNT=2.
  - One CMD_READY pop lets key 2 enter in the same cycle, so FIFO_COUNT stays 4.
- Saturation and grant-collision: 300 coalesced presses give DROP_CNT=255. A pulse on key k in its grant cycle leaves PENDING[k]=1, produces a second CMD_ID=k, and does not increment DROP_CNT.

Source files
------------

// File: rtl/key_scheduler.sv
// Round-robin scheduler: latches filtered key presses, grants one per cycle
// into a small FIFO that a consumer drains with a valid/ready handshake.

module key_req_lane (
    input  logic CLK,
    input  logic RST,
    input  logic pulse,
    input  logic gnt,
    output logic pending,
    output logic coalesce
);
    // A press landing on an already-pending, ungranted key folds into it.
    assign coalesce = pulse & pending & ~gnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pending <= 1'b0;
        else     pending <= (pending & ~gnt) | pulse;
    end
endmodule

module key_scheduler #(
    parameter int NKEYS = 4,
    parameter int DEPTH = 4,
    parameter int IDW   = $clog2(NKEYS),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [NKEYS-1:0] KEY_PULSE,
    input  logic             CMD_READY,
    output logic             CMD_VALID,
    output logic [IDW-1:0]   CMD_ID,
    output logic [NKEYS-1:0] PENDING,
    output logic [CW-1:0]    FIFO_COUNT,
    output logic [7:0]       DROP_CNT
);
    localparam int AW = $clog2(DEPTH);

    logic [NKEYS-1:0]          pend, coal, gnt;
    logic [IDW-1:0]            last, grant_id;
    logic                      found, grant_vld;
    logic [DEPTH-1:0][IDW-1:0] mem;
    logic [AW-1:0]             rd_ptr, wr_ptr;
    logic [CW-1:0]             count;
    logic [7:0]                drop_cnt;
    logic [3:0]                ncoal;
    logic [8:0]                dsum;
    logic                      pop, can_push;

    genvar k;
    generate
        for (k = 0; k < NKEYS; k++) begin : g_lane
            key_req_lane u_lane (
                .CLK      (CLK),
                .RST      (RST),
                .pulse    (KEY_PULSE[k]),
                .gnt      (gnt[k]),
                .pending  (pend[k]),
                .coalesce (coal[k])
            );
        end
    endgenerate

    assign pop      = (count != '0) && CMD_READY;
    assign can_push = (count != CW'(DEPTH)) || pop;

    // Search starts just past the last winner so every key gets a turn.
    always_comb begin
        int             idx;
        logic [IDW-1:0] idxv;
        found    = 1'b0;
        grant_id = '0;
        idx      = 0;
        idxv     = '0;
        for (int i = 1; i <= NKEYS; i++) begin
            idx = int'(last) + i;
            if (idx >= NKEYS) idx = idx - NKEYS;
            idxv = IDW'(idx);
            if (!found && pend[idxv]) begin
                found    = 1'b1;
                grant_id = idxv;
            end
        end
    end

    assign grant_vld = found && can_push;

    always_comb begin
        gnt = '0;
        if (grant_vld) gnt[grant_id] = 1'b1;
    end

    always_comb begin
        ncoal = '0;
        for (int i = 0; i < NKEYS; i++) ncoal = ncoal + 4'(coal[i]);
        dsum = {1'b0, drop_cnt} + {5'b0, ncoal};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last     <= IDW'(NKEYS - 1);
            mem      <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else begin
            drop_cnt <= dsum[8] ? 8'hFF : dsum[7:0];
            if (grant_vld) begin
                last        <= grant_id;
                mem[wr_ptr] <= grant_id;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (grant_vld && !pop)      count <= count + CW'(1);
            else if (pop && !grant_vld) count <= count - CW'(1);
        end
    end

    assign CMD_VALID  = (count != '0);
    assign CMD_ID     = CMD_VALID ? mem[rd_ptr] : '0;
    assign PENDING    = pend;
    assign FIFO_COUNT = count;
    assign DROP_CNT   = drop_cnt;
endmodule
